wam_round_ctrl: RTL and testbench

Round scheduler for the whack-a-mole game. It sits between the game-setup FSM/switches and the light and keypad controllers. It sequences each mole round (gap, then light on), picks the mole position from the LFSR value, and scores keypad hits and misses. It also enforces the game-mode end conditions: normal, timed, deathmatch and level continuity.

---
 rtl/wam_round_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_wam_round_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wam_round_ctrl.sv
// wam_round_ctrl -- whack-a-mole round scheduler.
// Sequences gap/light phases, picks the mole from the LFSR value, scores
// keypad hits/misses and enforces the normal/timed/deathmatch/continuity
// end conditions.
// Optional feature: define WAM_ROUND_CTRL_REPEAT_FILTER_EN to stop the same
// mole being shown twice in a row (first round after start is unfiltered).
module wam_round_ctrl #(
    parameter int SEC_CYCLES = 50_000_000,
    parameter int TIMED_SECS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] mode,
    input  logic [3:0] level,
    input  logic       extended,
    input  logic [3:0] rand_pos,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [8:0] led,
    output logic [3:0] light_pos,
    output logic [5:0] hits,
    output logic [5:0] misses,
    output logic [5:0] rounds,
    output logic [5:0] secs_left,
    output logic [1:0] level_cur,
    output logic       busy,
    output logic       game_over
);

    // Phase counter holds up to 2S-1, prescaler up to S-1.
    localparam int CW = $clog2(2 * SEC_CYCLES);
    localparam int PW = $clog2(SEC_CYCLES);

`ifdef WAM_ROUND_CTRL_REPEAT_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_ON, ST_DONE} state_t;
    typedef enum logic [1:0] {MD_NORMAL, MD_TIMED, MD_DEATH, MD_CONT} mode_t;

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [5:0]    limit_q, limit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          first_q, first_d;
    logic [8:0]    led_q, led_d;
    logic [3:0]    pos_q, pos_d;
    logic [5:0]    hits_q, hits_d;
    logic [5:0]    misses_q, misses_d;
    logic [5:0]    rounds_q, rounds_d;
    logic [5:0]    secs_q, secs_d;
    logic [1:0]    lvl_q, lvl_d;
    logic          busy_q, busy_d;
    logic          over_q, over_d;

    mode_t         start_mode;
    logic [1:0]    start_lvl;
    logic [1:0]    lvl_next;
    logic [3:0]    mapped_pos;
    logic [3:0]    pick_pos;
    logic          hit;
    logic          round_miss;
    logic          round_end;
    logic          timer_tick;
    logic          timer_expire;

    // Gap length minus one for a level index.
    function automatic logic [CW-1:0] gap_load(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return CW'(2 * SEC_CYCLES - 1);
            2'd1:    return CW'(SEC_CYCLES - 1);
            2'd2:    return CW'(SEC_CYCLES / 2 - 1);
            default: return CW'(SEC_CYCLES / 4 - 1);
        endcase
    endfunction

    // Light-on length minus one for a level index.
    function automatic logic [CW-1:0] on_load(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return CW'(2 * SEC_CYCLES - 1);
            2'd3:    return CW'(SEC_CYCLES / 2 - 1);
            default: return CW'(SEC_CYCLES - 1);
        endcase
    endfunction

    // Score counters stick at full scale instead of wrapping.
    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    function automatic mode_t decode_mode(input logic [3:0] m);
        case (m)
            4'b0010: return MD_TIMED;
            4'b0100: return MD_DEATH;
            4'b1000: return MD_CONT;
            default: return MD_NORMAL;
        endcase
    endfunction

    function automatic logic [1:0] decode_level(input logic [3:0] l);
        case (l)
            4'b0001: return 2'd0;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    // Next-state and next-output computation for the whole scheduler.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves it unassigned (no latches).
        state_d    = state_q;
        mode_d     = mode_q;
        limit_d    = limit_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        first_d    = first_q;
        led_d      = led_q;
        pos_d      = pos_q;
        hits_d     = hits_q;
        misses_d   = misses_q;
        rounds_d   = rounds_q;
        secs_d     = secs_q;
        lvl_d      = lvl_q;

        start_mode = decode_mode(mode);
        start_lvl  = (start_mode == MD_CONT) ? 2'd0 : decode_level(level);
        mapped_pos = (rand_pos >= 4'd9) ? rand_pos - 4'd9 : rand_pos;
        pick_pos   = (FILTER_EN && !first_q && mapped_pos == pos_q)
                     ? ((mapped_pos == 4'd8) ? 4'd0 : mapped_pos + 4'd1)
                     : mapped_pos;

        hit        = (state_q == ST_ON) && key_valid && (key == pos_q);
        round_miss = (state_q == ST_ON) && !hit &&
                     ((cnt_q == '0) || (key_valid && mode_q == MD_DEATH));
        round_end  = hit || round_miss;
        lvl_next   = lvl_q;
        if (mode_q == MD_CONT && rounds_q[2:0] == 3'd0 && lvl_q != 2'd3)
            lvl_next = lvl_q + 2'd1;

        timer_tick   = (mode_q == MD_TIMED) && (state_q == ST_GAP || state_q == ST_ON) &&
                       (pre_q == '0);
        timer_expire = timer_tick && (secs_q == 6'd1);
        if (state_q == ST_GAP || state_q == ST_ON) begin
            pre_d = timer_tick ? PW'(SEC_CYCLES - 1) : pre_q - PW'(1);
            if (timer_tick)
                secs_d = secs_q - 6'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_GAP;
                    mode_d   = start_mode;
                    limit_d  = extended ? 6'd50 : 6'd25;
                    lvl_d    = start_lvl;
                    secs_d   = (start_mode == MD_TIMED) ? 6'(TIMED_SECS) : 6'd0;
                    hits_d   = '0;
                    misses_d = '0;
                    rounds_d = '0;
                    led_d    = '0;
                    first_d  = 1'b1;
                    cnt_d    = gap_load(start_lvl);
                    pre_d    = PW'(SEC_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d  = ST_ON;
                    pos_d    = pick_pos;
                    led_d    = 9'd1 << pick_pos;
                    rounds_d = sat_inc(rounds_q);
                    first_d  = 1'b0;
                    cnt_d    = on_load(lvl_q);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin // ST_ON
                if (round_end) begin
                    led_d = '0;
                    lvl_d = lvl_next;
                    if (hit)
                        hits_d = sat_inc(hits_q);
                    else
                        misses_d = sat_inc(misses_q);
                    if ((mode_q == MD_DEATH && round_miss) ||
                        (mode_q != MD_TIMED && rounds_q == limit_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = gap_load(lvl_next);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase

        // Clock running out overrides the round outcome, but a same-cycle hit still scores.
        if (timer_expire) begin
            state_d = ST_DONE;
            led_d   = '0;
        end

        busy_d = (state_d == ST_GAP) || (state_d == ST_ON);
        over_d = (state_d == ST_DONE);
    end

    // State and registered outputs; reset clears everything to IDLE / zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MD_NORMAL;
            limit_q  <= '0;
            cnt_q    <= '0;
            pre_q    <= '0;
            first_q  <= 1'b0;
            led_q    <= '0;
            pos_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            rounds_q <= '0;
            secs_q   <= '0;
            lvl_q    <= '0;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state_q  <= state_d;
            mode_q   <= mode_d;
            limit_q  <= limit_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            first_q  <= first_d;
            led_q    <= led_d;
            pos_q    <= pos_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            rounds_q <= rounds_d;
            secs_q   <= secs_d;
            lvl_q    <= lvl_d;
            busy_q   <= busy_d;
            over_q   <= over_d;
        end
    end

    assign led       = led_q;
    assign light_pos = pos_q;
    assign hits      = hits_q;
    assign misses    = misses_q;
    assign rounds    = rounds_q;
    assign secs_left = secs_q;
    assign level_cur = lvl_q;
    assign busy      = busy_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_wam_round_ctrl.sv
// Self-checking bench for wam_round_ctrl (SEC_CYCLES=16, TIMED_SECS=4).
// A time-based game model predicts every output each cycle; directed
// scenarios pin the model with hand-computed values.
module tb_wam_round_ctrl;

    localparam int S  = 16;
    localparam int TS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] mode;
    logic [3:0] level;
    logic       extended;
    logic [3:0] rand_pos;
    logic       key_valid;
    logic [3:0] key;
    logic [8:0] led;
    logic [3:0] light_pos;
    logic [5:0] hits, misses, rounds, secs_left;
    logic [1:0] level_cur;
    logic       busy, game_over;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    wam_round_ctrl #(.SEC_CYCLES(S), .TIMED_SECS(TS)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .level(level),
        .extended(extended), .rand_pos(rand_pos), .key_valid(key_valid), .key(key),
        .led(led), .light_pos(light_pos), .hits(hits), .misses(misses),
        .rounds(rounds), .secs_left(secs_left), .level_cur(level_cur),
        .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    localparam int NORMAL = 0, TIMED = 1, DEATH = 2, CONT = 3;

    bit         m_busy, m_over, m_shown, m_first;
    int         m_t, m_t0, m_end, m_mode, m_lvl, m_limit;
    int         m_hits, m_misses, m_rounds, m_secs, m_pos;
    logic [8:0] m_led;

    function automatic int mode_of(input logic [3:0] m);
        case (m)
            4'b0010: return TIMED;
            4'b0100: return DEATH;
            4'b1000: return CONT;
            default: return NORMAL;
        endcase
    endfunction

    function automatic int level_of(input logic [3:0] l);
        case (l)
            4'b0001: return 0;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int gap_cycles(input int l);
        case (l)
            0: return 2 * S;
            1: return S;
            2: return S / 2;
            default: return S / 4;
        endcase
    endfunction

    function automatic int on_cycles(input int l);
        case (l)
            0: return 2 * S;
            3: return S / 2;
            default: return S;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 63) ? 63 : v;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_over = 0; m_shown = 0; m_first = 0;
        m_mode = NORMAL; m_lvl = 0; m_limit = 0;
        m_hits = 0; m_misses = 0; m_rounds = 0; m_secs = 0; m_pos = 0;
        m_led = '0;
    endtask

    task automatic model_finish();
        m_busy = 0; m_over = 1; m_shown = 0; m_led = '0;
    endtask

    task automatic model_edge();
        int  p;
        bit  timeout, hit, miss;
        m_t++;
        if (!m_busy) begin
            if (start) begin
                m_t0 = m_t;
                m_mode = mode_of(mode);
                m_lvl = (m_mode == CONT) ? 0 : level_of(level);
                m_limit = extended ? 50 : 25;
                m_secs = (m_mode == TIMED) ? TS : 0;
                m_hits = 0; m_misses = 0; m_rounds = 0;
                m_busy = 1; m_over = 0; m_shown = 0; m_first = 1; m_led = '0;
                m_end = m_t + gap_cycles(m_lvl);
            end
        end else begin
            timeout = (m_mode == TIMED) && (m_t - m_t0 == TS * S);
            if (!m_shown) begin
                if (m_t == m_end) begin
                    p = (int'(rand_pos) >= 9) ? int'(rand_pos) - 9 : int'(rand_pos);
`ifdef WAM_ROUND_CTRL_REPEAT_FILTER_EN
                    if (!m_first && p == m_pos) p = (p + 1) % 9;
`endif
                    m_first = 0;
                    m_pos = p;
                    m_shown = 1;
                    m_rounds = sat(m_rounds + 1);
                    m_led = 9'(1 << p);
                    m_end = m_t + on_cycles(m_lvl);
                end
            end else begin
                hit  = key_valid && (int'(key) == m_pos);
                miss = !hit && ((m_t == m_end) || (key_valid && m_mode == DEATH));
                if (hit || miss) begin
                    m_shown = 0;
                    m_led = '0;
                    if (hit) m_hits = sat(m_hits + 1);
                    else     m_misses = sat(m_misses + 1);
                    if (m_mode == CONT && m_rounds % 8 == 0 && m_lvl < 3) m_lvl++;
                    if ((m_mode == DEATH && miss) || (m_mode != TIMED && m_rounds == m_limit))
                        model_finish();
                    else
                        m_end = m_t + gap_cycles(m_lvl);
                end
            end
            if (m_mode == TIMED) m_secs = TS - (m_t - m_t0) / S;
            if (timeout) model_finish();
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else model_edge();
    end

    function automatic logic [63:0] dut_vec();
        return 64'({led, light_pos, hits, misses, rounds, secs_left, level_cur, busy, game_over});
    endfunction

    function automatic logic [63:0] model_vec();
        return 64'({m_led, 4'(m_pos), 6'(m_hits), 6'(m_misses), 6'(m_rounds), 6'(m_secs),
                    2'(m_lvl), m_busy, m_over});
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) check("cycle_outputs", dut_vec(), model_vec());
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_game(input logic [3:0] md, input logic [3:0] lv, input logic ext);
        @(negedge clk);
        mode = md; level = lv; extended = ext; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
    endtask

    task automatic wait_led(input bit on, input int budget);
        int c = 0;
        while (((led != 0) != on) && c < budget) begin
            tick(1);
            c++;
        end
        check("wait_led_bound", 64'(c < budget), 64'd1);
    endtask

    task automatic wait_over(input int budget, output int n);
        n = 0;
        while (!game_over && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_over_bound", 64'(n < budget), 64'd1);
    endtask

    int n;
    int seq_exp[4];
    int seq_got[4];

    initial begin
        reset = 1'b1; start = 1'b0; mode = 4'b0001; level = 4'b0010; extended = 1'b0;
        rand_pos = 4'd0; key_valid = 1'b0; key = 4'd0;
        tick(3);
        reset = 1'b0;
        cmp_en = 1'b1;
        check("reset_outputs", dut_vec(), 64'd0);

        // Normal, level 2, 25 rounds, no presses: 32 cycles per round.
        rand_pos = 4'd5;
        start_game(4'b0001, 4'b0010, 1'b0);
        check("busy_after_start", 64'(busy), 64'd1);
        tick(15); check("gap_led_off", 64'(led), 64'h000);
        tick(1);  check("led_rise", 64'(led), 64'h020);
        tick(15); check("led_held", 64'(led), 64'h020);
        tick(1);  check("led_timeout", 64'(led), 64'h000);
        wait_over(1000, n);
        check("normal_length", 64'(32 + n), 64'd800);
        check("normal_misses", 64'(misses), 64'd25);
        check("normal_hits", 64'(hits), 64'd0);
        check("normal_rounds", 64'(rounds), 64'd25);

        // Hit: rand_pos 12 maps to position 3.
        rand_pos = 4'd12;
        start_game(4'b0001, 4'b0010, 1'b0);
        tick(16);
        check("hit_led", 64'(led), 64'h008);
        check("hit_pos", 64'(light_pos), 64'd3);
        tick(4);
        key = 4'd3; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        check("hit_count", 64'(hits), 64'd1);
        check("hit_led_off", 64'(led), 64'h000);
        tick(15); check("hit_gap_off", 64'(led), 64'h000);
        tick(1);  check("hit_next_led", 64'(led), 64'h008);
        pulse_reset();

        // Deathmatch wrong key ends the game.
        start_game(4'b0100, 4'b0010, 1'b0);
        tick(16);
        key = 4'd2; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        check("dm_over", 64'(game_over), 64'd1);
        check("dm_misses", 64'(misses), 64'd1);
        check("dm_rounds", 64'(rounds), 64'd1);

        // Timed with level-2 timing: two moles fit in the 64-cycle game.
        start_game(4'b0010, 4'b0010, 1'b0);
        check("timed_secs0", 64'(secs_left), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            tick(15); check("timed_running", 64'(game_over), 64'd0);
            tick(1);  check("timed_secs", 64'(secs_left), 64'(4 - i));
        end
        check("timed_over", 64'(game_over), 64'd1);
        check("timed_rounds", 64'(rounds), 64'd2);

        // Repeated LFSR value with and without the repeat filter.
`ifdef WAM_ROUND_CTRL_REPEAT_FILTER_EN
        seq_exp = '{3, 4, 3, 4};
`else
        seq_exp = '{3, 3, 3, 3};
`endif
        rand_pos = 4'd3;
        start_game(4'b0001, 4'b1000, 1'b0);
        for (int r = 0; r < 4; r++) begin
            wait_led(1'b1, 30);
            seq_got[r] = int'(light_pos);
            check("repeat_pos", 64'(seq_got[r]), 64'(seq_exp[r]));
            wait_led(1'b0, 30);
        end
        pulse_reset();

        // Reset while a mole is lit, then a fresh game.
        start_game(4'b0001, 4'b1000, 1'b0);
        wait_led(1'b1, 30);
        @(negedge clk); #2 reset = 1'b1;
        #1 check("reset_async", dut_vec(), 64'd0);
        @(negedge clk);
        check("reset_held", dut_vec(), 64'd0);
        #2 reset = 1'b0;
        start_game(4'b0001, 4'b1000, 1'b0);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_rounds", 64'(rounds), 64'd0);
        tick(4);
        check("restart_led", 64'(led != 0), 64'd1);
        pulse_reset();

        // Randomized games checked cycle by cycle against the model.
        for (int g = 0; g < 14; g++) begin
            logic [3:0] md, lv;
            int c;
            case ($urandom_range(0, 4))
                0: md = 4'b0001;
                1: md = 4'b0010;
                2: md = 4'b0100;
                3: md = 4'b1000;
                default: md = 4'($urandom);
            endcase
            lv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            start_game(md, lv, 1'($urandom_range(0, 1)));
            c = 0;
            while (busy && c < 4000) begin
                rand_pos  = 4'($urandom_range(0, 15));
                key_valid = ($urandom_range(0, 7) == 0);
                key       = ($urandom_range(0, 1) == 1) ? 4'(m_pos) : 4'($urandom_range(0, 8));
                start     = ($urandom_range(0, 40) == 0);
                if (g == 6 && c == 100) begin
                    #2 reset = 1'b1;
                    #5 reset = 1'b0;
                end
                tick(1);
                c++;
            end
            start = 1'b0;
            key_valid = 1'b0;
            check("random_game_ends", 64'(c < 4000), 64'd1);
            tick(3);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
